// File: rtl/nv_ram_rwsp_80x256_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : nv_ram_rwsp_80x256_fifo_ctrl
//  Brief    : Valid/ready FIFO controller around an external 1R1W RAM with a
//             two-stage read path (re -> ore) and an output skid buffer.
//  Revision : 1.0
// ============================================================================
module nv_ram_rwsp_80x256_fifo_ctrl #(
  parameter int DEPTH = 80,
  parameter int AW    = 7,
  parameter int DW    = 256,
  parameter int OBUF  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic          ram_we,
  output logic [AW-1:0] ram_wa,
  output logic [DW-1:0] ram_di,
  output logic          ram_re,
  output logic [AW-1:0] ram_ra,
  output logic          ram_ore,
  input  logic [DW-1:0] ram_dout,
  output logic [6:0]    fifo_cnt
);

  localparam int c_CW = $clog2(DEPTH + 1);
  localparam int c_BW = $clog2(OBUF + 1);
  localparam int c_HW = (OBUF > 1) ? $clog2(OBUF) : 1;
  localparam int c_PW = $clog2(OBUF + 3);

  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [c_CW-1:0] r_ram_cnt;
  logic            r_p1;
  logic            r_p2;
  logic [c_BW-1:0] r_buf_cnt;
  logic [c_HW-1:0] r_head;
  logic [c_HW-1:0] r_tail;
  logic [DW-1:0]   r_buf [OBUF];

  logic            w_push;
  logic            w_issue;
  logic            w_pop;
  logic [c_PW-1:0] w_pending;

  function automatic logic [AW-1:0] f_inc_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  function automatic logic [c_HW-1:0] f_inc_idx(input logic [c_HW-1:0] p);
    return (p == c_HW'(OBUF - 1)) ? '0 : p + c_HW'(1);
  endfunction

  // Reads already committed to the skid buffer: held entries plus both stages.
  assign w_pending = c_PW'(r_buf_cnt) + c_PW'(r_p1) + c_PW'(r_p2);

  assign wr_prdy = !rst && (r_ram_cnt != c_CW'(DEPTH));
  assign w_push  = wr_pvld && wr_prdy;
  assign w_issue = !rst && (r_ram_cnt != '0) && (w_pending < c_PW'(OBUF));
  assign w_pop   = rd_pvld && rd_prdy;

  assign ram_we   = w_push;
  assign ram_wa   = r_wr_ptr;
  assign ram_di   = wr_pd;
  assign ram_re   = w_issue;
  assign ram_ra   = r_rd_ptr;
  assign ram_ore  = r_p1;
  assign rd_pvld  = (r_buf_cnt != '0);
  assign rd_pd    = r_buf[r_head];
  assign fifo_cnt = 7'(r_ram_cnt) + 7'(r_p1) + 7'(r_p2) + 7'(r_buf_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= '0;
      r_p1      <= 1'b0;
      r_p2      <= 1'b0;
      r_buf_cnt <= '0;
      r_head    <= '0;
      r_tail    <= '0;
    end else begin
      r_p1 <= w_issue;
      r_p2 <= r_p1;

      if (w_push) begin
        r_wr_ptr <= f_inc_ptr(r_wr_ptr);
      end
      if (w_issue) begin
        r_rd_ptr <= f_inc_ptr(r_rd_ptr);
      end

      case ({w_push, w_issue})
        2'b10:   r_ram_cnt <= r_ram_cnt + c_CW'(1);
        2'b01:   r_ram_cnt <= r_ram_cnt - c_CW'(1);
        default: r_ram_cnt <= r_ram_cnt;
      endcase

      if (r_p2) begin
        r_tail <= f_inc_idx(r_tail);
      end
      if (w_pop) begin
        r_head <= f_inc_idx(r_head);
      end

      case ({r_p2, w_pop})
        2'b10:   r_buf_cnt <= r_buf_cnt + c_BW'(1);
        2'b01:   r_buf_cnt <= r_buf_cnt - c_BW'(1);
        default: r_buf_cnt <= r_buf_cnt;
      endcase
    end
  end

  // Skid storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (r_p2) begin
      r_buf[r_tail] <= ram_dout;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nv_ram_rwsp_80x256_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nv_ram_rwsp_80x256_fifo_ctrl
//  Brief    : Self-checking bench: directed vector table, fill/wrap, streaming,
//             random traffic against a queue model, reset during a read.
//  Revision : 1.0
// ============================================================================
module tb_nv_ram_rwsp_80x256_fifo_ctrl;

  localparam int DEPTH = 80;
  localparam int AW    = 7;
  localparam int DW    = 256;
  localparam int OBUF  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_pvld = 1'b0;
  logic          rd_prdy = 1'b0;
  logic [DW-1:0] wr_pd = '0;
  logic          wr_prdy, rd_pvld, ram_we, ram_re, ram_ore;
  logic [DW-1:0] rd_pd, ram_di, ram_dout;
  logic [AW-1:0] ram_wa, ram_ra;
  logic [6:0]    fifo_cnt;

  always #5 clk = ~clk;

  nv_ram_rwsp_80x256_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .OBUF(OBUF)) dut (
    .clk(clk), .rst(rst),
    .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
    .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
    .ram_we(ram_we), .ram_wa(ram_wa), .ram_di(ram_di),
    .ram_re(ram_re), .ram_ra(ram_ra), .ram_ore(ram_ore),
    .ram_dout(ram_dout), .fifo_cnt(fifo_cnt)
  );

  // External RAM: address register on re, output register on ore.
  logic [DW-1:0] mem [0:127];
  logic [AW-1:0] ra_q = '0;
  logic [DW-1:0] dout_q = '0;
  assign ram_dout = dout_q;
  always @(posedge clk) begin
    if (ram_we)  mem[ram_wa] <= ram_di;
    if (ram_re)  ra_q <= ram_ra;
    if (ram_ore) dout_q <= mem[ra_q];
  end

  int n_tot = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: stored data in order, issued-but-unpopped reads tagged
  // with their issue cycle (visible three cycles after issue).
  logic [DW-1:0] m_q[$];
  int            m_iss[$];
  int            m_p = 0, m_i = 0, m_o = 0, m_cyc = 0;
  logic          m_prev_re = 1'b0;
  bit            saw_wa_wrap = 0, saw_ra_wrap = 0;

  always @(negedge clk) begin : mon
    int ram_n;
    bit e_re, e_pv;
    if (rst) begin
      chk("rst_zero", {wr_prdy, rd_pvld, ram_we, ram_re, ram_ore, fifo_cnt, ram_wa, ram_ra}, '0);
      m_q.delete(); m_iss.delete();
      m_p = 0; m_i = 0; m_o = 0; m_prev_re = 1'b0;
    end else begin
      ram_n = m_p - m_i;
      e_re  = (ram_n > 0) && (m_iss.size() < OBUF);
      e_pv  = (m_iss.size() > 0) && (m_cyc - m_iss[0] >= 3);
      chk("fifo_cnt", fifo_cnt, m_q.size());
      chk("wr_prdy", wr_prdy, ram_n != DEPTH);
      chk("ram_re", ram_re, e_re);
      chk("ram_ore", ram_ore, m_prev_re);
      chk("ram_we", ram_we, wr_pvld && (ram_n != DEPTH));
      chk("rd_pvld", rd_pvld, e_pv);
      if (rd_pvld && rd_prdy && m_q.size() > 0) begin
        chk("rd_pd", rd_pd, m_q[0]);
        void'(m_q.pop_front());
        if (m_iss.size() > 0) void'(m_iss.pop_front());
        m_o++;
      end
      if (ram_we) begin
        chk("ram_wa", ram_wa, m_p % DEPTH);
        chk("ram_di", ram_di, wr_pd);
        if (m_p > 0 && ram_wa == 0) saw_wa_wrap = 1;
        m_q.push_back(wr_pd);
        m_p++;
      end
      if (ram_re) begin
        chk("ram_ra", ram_ra, m_i % DEPTH);
        if (m_i > 0 && ram_ra == 0) saw_ra_wrap = 1;
        m_iss.push_back(m_cyc);
        m_i++;
      end
      m_prev_re = ram_re;
    end
    m_cyc++;
  end

  typedef struct {
    logic       wv;
    logic [7:0] d;
    logic       we;
    logic [6:0] wa;
    logic       re;
    logic [6:0] ra;
    logic       ore;
    logic       pv;
    logic [7:0] pd;
    logic [6:0] cnt;
  } vec_t;

  function automatic vec_t mk(int wv, int d, int we, int wa, int re, int ra,
                              int ore, int pv, int pd, int cnt);
    vec_t v;
    v.wv = wv[0]; v.d = d[7:0]; v.we = we[0]; v.wa = wa[6:0]; v.re = re[0];
    v.ra = ra[6:0]; v.ore = ore[0]; v.pv = pv[0]; v.pd = pd[7:0]; v.cnt = cnt[6:0];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_pd();
    for (int j = 0; j < 8; j++) wr_pd[j*32 +: 32] = $urandom();
  endtask

  task automatic drain();
    wr_pvld = 1'b0;
    rd_prdy = 1'b1;
    for (int n = 0; n < 300 && m_q.size() > 0; n++) tick();
    @(negedge clk);
    chk("drain_cnt", fifo_cnt, 0);
    chk("drain_pvld", rd_pvld, 0);
    tick();
    rd_prdy = 1'b0;
  endtask

  task automatic fill_drain(input int rep);
    int acc, i0;
    acc = 0;
    i0  = m_i;
    rd_prdy = 1'b0;
    for (int k = 0; k < 200 && acc < DEPTH + OBUF; k++) begin
      wr_pvld = 1'b1;
      rnd_pd();
      @(negedge clk);
      if (wr_prdy) acc++;
      tick();
    end
    wr_pvld = 1'b0;
    chk($sformatf("fill%0d_accepts", rep), acc, DEPTH + OBUF);
    repeat (3) tick();
    @(negedge clk);
    chk($sformatf("fill%0d_prdy", rep), wr_prdy, 0);
    chk($sformatf("fill%0d_cnt", rep), fifo_cnt, DEPTH + OBUF);
    chk($sformatf("fill%0d_issues", rep), m_i - i0, OBUF);
    tick();
    drain();
  endtask

  vec_t tbl[13];

  initial begin
    int bubbles;
    bit found;

    tbl[0]  = mk(1, 'hA5, 1, 0, 0, 0, 0, 0, 'h00, 0);
    tbl[1]  = mk(0, 'h00, 0, 0, 1, 0, 0, 0, 'h00, 1);
    tbl[2]  = mk(0, 'h00, 0, 0, 0, 0, 1, 0, 'h00, 1);
    tbl[3]  = mk(0, 'h00, 0, 0, 0, 0, 0, 0, 'h00, 1);
    tbl[4]  = mk(0, 'h00, 0, 0, 0, 0, 0, 1, 'hA5, 1);
    tbl[5]  = mk(0, 'h00, 0, 0, 0, 0, 0, 0, 'h00, 0);
    tbl[6]  = mk(1, 'h3C, 1, 1, 0, 0, 0, 0, 'h00, 0);
    tbl[7]  = mk(1, 'hC3, 1, 2, 1, 1, 0, 0, 'h00, 1);
    tbl[8]  = mk(0, 'h00, 0, 0, 1, 2, 1, 0, 'h00, 2);
    tbl[9]  = mk(0, 'h00, 0, 0, 0, 0, 1, 0, 'h00, 2);
    tbl[10] = mk(0, 'h00, 0, 0, 0, 0, 0, 1, 'h3C, 2);
    tbl[11] = mk(0, 'h00, 0, 0, 0, 0, 0, 1, 'hC3, 1);
    tbl[12] = mk(0, 'h00, 0, 0, 0, 0, 0, 0, 'h00, 0);

    // Reset and idle
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_prdy", wr_prdy, 1);
    chk("idle_cnt", fifo_cnt, 0);
    chk("idle_outs", {rd_pvld, ram_we, ram_re, ram_ore}, 0);
    tick();

    // Directed vectors: single word, then a back-to-back pair
    for (int i = 0; i < 13; i++) begin
      wr_pvld = tbl[i].wv;
      wr_pd   = {32{tbl[i].d}};
      rd_prdy = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_we", i), ram_we, tbl[i].we);
      if (tbl[i].we) chk($sformatf("vec%0d_wa", i), ram_wa, tbl[i].wa);
      chk($sformatf("vec%0d_re", i), ram_re, tbl[i].re);
      if (tbl[i].re) chk($sformatf("vec%0d_ra", i), ram_ra, tbl[i].ra);
      chk($sformatf("vec%0d_ore", i), ram_ore, tbl[i].ore);
      chk($sformatf("vec%0d_pvld", i), rd_pvld, tbl[i].pv);
      if (tbl[i].pv) chk($sformatf("vec%0d_pd", i), rd_pd, {32{tbl[i].pd}});
      chk($sformatf("vec%0d_cnt", i), fifo_cnt, tbl[i].cnt);
      chk($sformatf("vec%0d_prdy", i), wr_prdy, 1);
      tick();
    end
    wr_pvld = 1'b0;
    rd_prdy = 1'b0;

    // Fill to capacity with backpressure, drain, twice (pointer wrap)
    fill_drain(0);
    fill_drain(1);
    chk("wa_wrapped", saw_wa_wrap, 1);
    chk("ra_wrapped", saw_ra_wrap, 1);

    // Streaming: continuous push and pop
    bubbles = 0;
    for (int k = 0; k < 500; k++) begin
      wr_pvld = 1'b1;
      rd_prdy = 1'b1;
      rnd_pd();
      @(negedge clk);
      if (k >= 4 && !rd_pvld) bubbles++;
      tick();
    end
    chk("stream_bubbles", bubbles, 0);
    drain();

    // Random traffic at 50% on both sides
    for (int k = 0; k < 10000; k++) begin
      wr_pvld = $urandom_range(0, 1);
      rd_prdy = $urandom_range(0, 1);
      rnd_pd();
      tick();
    end
    drain();

    // Reset while a read is in the output stage
    rd_prdy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      wr_pvld = 1'b1;
      rnd_pd();
      tick();
    end
    wr_pvld = 1'b0;
    repeat (2) tick();
    rd_prdy = 1'b1;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ram_ore) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("ore_seen", found, 1);
    #1 rst = 1'b1;
    rd_prdy = 1'b0;
    @(negedge clk);
    chk("midrst_outs", {wr_prdy, rd_pvld, ram_we, ram_re, ram_ore, fifo_cnt}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("postrst_cnt", fifo_cnt, 0);
    chk("postrst_pvld", rd_pvld, 0);
    tick();
    wr_pvld = 1'b1;
    wr_pd   = 256'h1;
    tick();
    wr_pvld = 1'b0;
    rd_prdy = 1'b1;
    found = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rd_pvld) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("postrst_pvld_seen", found, 1);
    chk("postrst_data", rd_pd, 256'h1);
    tick();
    @(negedge clk);
    chk("postrst_empty", fifo_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
